hqm_sberep_mst: RTL and testbench

HQM_SBEREP_MST -- requirements
Module: hqm_sberep_mst

---
 rtl/hqm_sberep_mst.sv | 129 ++++++++++++
 tb/tb_hqm_sberep_mst.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hqm_sberep_mst.sv
// Sideband repeater, master side: two independent 2-entry flop FIFOs (PC and NP) between IP and EP.
// NP flits carry a fence count so they never overtake PC flits queued before or alongside them.
module hqm_sberep_mst #(
    parameter int INTERNALPLDBIT = 31
) (
    input  logic                    agent_clk,
    input  logic                    agent_rst_b,

    input  logic                    sbi_sbe_mmsg_pcirdy_ip,
    input  logic                    sbi_sbe_mmsg_npirdy_ip,
    input  logic                    sbi_sbe_mmsg_pceom_ip,
    input  logic                    sbi_sbe_mmsg_npeom_ip,
    input  logic                    sbi_sbe_mmsg_pcparity_ip,
    input  logic                    sbi_sbe_mmsg_npparity_ip,
    input  logic [INTERNALPLDBIT:0] sbi_sbe_mmsg_pcpayload_ip,
    input  logic [INTERNALPLDBIT:0] sbi_sbe_mmsg_nppayload_ip,
    output logic                    sbe_sbi_mmsg_pctrdy_ip,
    output logic                    sbe_sbi_mmsg_nptrdy_ip,
    output logic                    sbe_sbi_mmsg_pcmsgip_ip,
    output logic                    sbe_sbi_mmsg_npmsgip_ip,

    output logic                    sbi_sbe_mmsg_pcirdy_ep,
    output logic                    sbi_sbe_mmsg_npirdy_ep,
    output logic                    sbi_sbe_mmsg_pceom_ep,
    output logic                    sbi_sbe_mmsg_npeom_ep,
    output logic                    sbi_sbe_mmsg_pcparity_ep,
    output logic                    sbi_sbe_mmsg_npparity_ep,
    output logic [INTERNALPLDBIT:0] sbi_sbe_mmsg_pcpayload_ep,
    output logic [INTERNALPLDBIT:0] sbi_sbe_mmsg_nppayload_ep,
    input  logic                    sbe_sbi_mmsg_pctrdy_ep,
    input  logic                    sbe_sbi_mmsg_nptrdy_ep,

    output logic [1:0]              empty_mst
);

    localparam int EW = INTERNALPLDBIT + 3;

    logic [1:0]              irdyIp, eomIp, parityIp, trdyIp;
    logic [1:0]              irdyEp, eomEp, parityEp, trdyEp;
    logic [INTERNALPLDBIT:0] payloadIp [2];
    logic [INTERNALPLDBIT:0] payloadEp [2];

    logic [EW-1:0] mem_q   [2][2];
    logic [1:0]    wrPtr_q [2];
    logic [1:0]    wrPtr_d [2];
    logic [1:0]    rdPtr_q [2];
    logic [1:0]    rdPtr_d [2];
    logic [1:0]    fence_q [2];
    logic [1:0]    fence_d [2];
    logic [1:0]    msgIp_q, msgIp_d;
    logic [1:0]    full, empty, push, pop;
    logic [1:0]    pcOccNext;

    assign irdyIp       = {sbi_sbe_mmsg_npirdy_ip,   sbi_sbe_mmsg_pcirdy_ip};
    assign eomIp        = {sbi_sbe_mmsg_npeom_ip,    sbi_sbe_mmsg_pceom_ip};
    assign parityIp     = {sbi_sbe_mmsg_npparity_ip, sbi_sbe_mmsg_pcparity_ip};
    assign payloadIp[0] = sbi_sbe_mmsg_pcpayload_ip;
    assign payloadIp[1] = sbi_sbe_mmsg_nppayload_ip;
    assign trdyEp       = {sbe_sbi_mmsg_nptrdy_ep,   sbe_sbi_mmsg_pctrdy_ep};

    for (genvar c = 0; c < 2; c++) begin : gClass
        assign empty[c]  = (wrPtr_q[c] == rdPtr_q[c]);
        assign full[c]   = (wrPtr_q[c][0] == rdPtr_q[c][0]) && (wrPtr_q[c][1] != rdPtr_q[c][1]);
        assign trdyIp[c] = ~full[c];
        assign push[c]   = irdyIp[c] & trdyIp[c];
        assign pop[c]    = irdyEp[c] & trdyEp[c];
        assign {eomEp[c], parityEp[c], payloadEp[c]} = mem_q[c][rdPtr_q[c][0]];
        assign wrPtr_d[c] = wrPtr_q[c] + {1'b0, push[c]};
        assign rdPtr_d[c] = rdPtr_q[c] + {1'b0, pop[c]};
        assign msgIp_d[c] = push[c] ? ~eomIp[c] : msgIp_q[c];
    end

    // NP head is held back while any PC flit that preceded it is still queued
    assign irdyEp[0] = ~empty[0];
    assign irdyEp[1] = ~empty[1] & (fence_q[rdPtr_q[1][0]] == 2'd0);

    assign pcOccNext = wrPtr_d[0] - rdPtr_d[0];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            fence_d[i] = fence_q[i];
            if (pop[0] && (fence_q[i] != 2'd0)) begin
                fence_d[i] = fence_q[i] - 2'd1;
            end
        end
        if (push[1]) begin
            fence_d[wrPtr_q[1][0]] = pcOccNext;
        end
    end

    always_ff @(posedge agent_clk or negedge agent_rst_b) begin
        if (!agent_rst_b) begin
            for (int c = 0; c < 2; c++) begin
                wrPtr_q[c] <= '0;
                rdPtr_q[c] <= '0;
                fence_q[c] <= '0;
                for (int e = 0; e < 2; e++) begin
                    mem_q[c][e] <= '0;
                end
            end
            msgIp_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                wrPtr_q[c] <= wrPtr_d[c];
                rdPtr_q[c] <= rdPtr_d[c];
                fence_q[c] <= fence_d[c];
                if (push[c]) begin
                    mem_q[c][wrPtr_q[c][0]] <= {eomIp[c], parityIp[c], payloadIp[c]};
                end
            end
            msgIp_q <= msgIp_d;
        end
    end

    assign sbe_sbi_mmsg_pctrdy_ip    = trdyIp[0];
    assign sbe_sbi_mmsg_nptrdy_ip    = trdyIp[1];
    assign sbe_sbi_mmsg_pcmsgip_ip   = msgIp_q[0];
    assign sbe_sbi_mmsg_npmsgip_ip   = msgIp_q[1];
    assign sbi_sbe_mmsg_pcirdy_ep    = irdyEp[0];
    assign sbi_sbe_mmsg_npirdy_ep    = irdyEp[1];
    assign sbi_sbe_mmsg_pceom_ep     = eomEp[0];
    assign sbi_sbe_mmsg_npeom_ep     = eomEp[1];
    assign sbi_sbe_mmsg_pcparity_ep  = parityEp[0];
    assign sbi_sbe_mmsg_npparity_ep  = parityEp[1];
    assign sbi_sbe_mmsg_pcpayload_ep = payloadEp[0];
    assign sbi_sbe_mmsg_nppayload_ep = payloadEp[1];
    assign empty_mst                 = empty;

endmodule

// File: tb/tb_hqm_sberep_mst.sv
// Scoreboard bench for hqm_sberep_mst: issued flits queue their expected EP image,
// a negedge monitor compares on every EP handshake; directed checks cover timing, fencing and reset.
module tb_hqm_sberep_mst;

    typedef struct packed {
        logic        eom;
        logic        parity;
        logic [31:0] payload;
    } flit_t;

    logic        clk = 1'b0;
    logic        rstB;
    logic        pcIrdyIp, npIrdyIp, pcEomIp, npEomIp, pcParityIp, npParityIp;
    logic [31:0] pcPayloadIp, npPayloadIp;
    logic        pcTrdyIp, npTrdyIp, pcMsgIp, npMsgIp;
    logic        pcIrdyEp, npIrdyEp, pcEomEp, npEomEp, pcParityEp, npParityEp;
    logic [31:0] pcPayloadEp, npPayloadEp;
    logic        pcTrdyEp, npTrdyEp;
    logic [1:0]  emptyMst;

    flit_t pcExp[$];
    flit_t npExp[$];
    int    passCount  = 0;
    int    checkCount = 0;

    hqm_sberep_mst #(.INTERNALPLDBIT(31)) dut (
        .agent_clk                 (clk),
        .agent_rst_b               (rstB),
        .sbi_sbe_mmsg_pcirdy_ip    (pcIrdyIp),
        .sbi_sbe_mmsg_npirdy_ip    (npIrdyIp),
        .sbi_sbe_mmsg_pceom_ip     (pcEomIp),
        .sbi_sbe_mmsg_npeom_ip     (npEomIp),
        .sbi_sbe_mmsg_pcparity_ip  (pcParityIp),
        .sbi_sbe_mmsg_npparity_ip  (npParityIp),
        .sbi_sbe_mmsg_pcpayload_ip (pcPayloadIp),
        .sbi_sbe_mmsg_nppayload_ip (npPayloadIp),
        .sbe_sbi_mmsg_pctrdy_ip    (pcTrdyIp),
        .sbe_sbi_mmsg_nptrdy_ip    (npTrdyIp),
        .sbe_sbi_mmsg_pcmsgip_ip   (pcMsgIp),
        .sbe_sbi_mmsg_npmsgip_ip   (npMsgIp),
        .sbi_sbe_mmsg_pcirdy_ep    (pcIrdyEp),
        .sbi_sbe_mmsg_npirdy_ep    (npIrdyEp),
        .sbi_sbe_mmsg_pceom_ep     (pcEomEp),
        .sbi_sbe_mmsg_npeom_ep     (npEomEp),
        .sbi_sbe_mmsg_pcparity_ep  (pcParityEp),
        .sbi_sbe_mmsg_npparity_ep  (npParityEp),
        .sbi_sbe_mmsg_pcpayload_ep (pcPayloadEp),
        .sbi_sbe_mmsg_nppayload_ep (npPayloadEp),
        .sbe_sbi_mmsg_pctrdy_ep    (pcTrdyEp),
        .sbe_sbi_mmsg_nptrdy_ep    (npTrdyEp),
        .empty_mst                 (emptyMst)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Drive one flit on a class (0=PC, 1=NP) and queue what EP must later see; inputs persist until idled
    task automatic applyStimulus(input bit cls, input logic eom, input logic parity, input logic [31:0] payload);
        flit_t f;
        f = '{eom: eom, parity: parity, payload: payload};
        if (cls == 1'b0) begin
            pcIrdyIp = 1'b1; pcEomIp = eom; pcParityIp = parity; pcPayloadIp = payload;
            pcExp.push_back(f);
        end else begin
            npIrdyIp = 1'b1; npEomIp = eom; npParityIp = parity; npPayloadIp = payload;
            npExp.push_back(f);
        end
    endtask

    task automatic idleIp(input bit cls);
        if (cls == 1'b0) pcIrdyIp = 1'b0;
        else             npIrdyIp = 1'b0;
    endtask

    task automatic cycleStart();
        @(posedge clk);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    // Monitor: every EP handshake must match the oldest outstanding flit of that class
    always @(negedge clk) begin : pcMonitor
        flit_t f;
        if (rstB && pcIrdyEp && pcTrdyEp) begin
            if (pcExp.size() == 0) begin
                checkOutput("pc_unexpected_pop", 32'd1, 32'd0);
            end else begin
                f = pcExp.pop_front();
                checkOutput("pc_payload", pcPayloadEp, f.payload);
                checkOutput("pc_eom",     {31'd0, pcEomEp},    {31'd0, f.eom});
                checkOutput("pc_parity",  {31'd0, pcParityEp}, {31'd0, f.parity});
            end
        end
    end

    always @(negedge clk) begin : npMonitor
        flit_t f;
        if (rstB && npIrdyEp && npTrdyEp) begin
            if (npExp.size() == 0) begin
                checkOutput("np_unexpected_pop", 32'd1, 32'd0);
            end else begin
                f = npExp.pop_front();
                checkOutput("np_payload", npPayloadEp, f.payload);
                checkOutput("np_eom",     {31'd0, npEomEp},    {31'd0, f.eom});
                checkOutput("np_parity",  {31'd0, npParityEp}, {31'd0, f.parity});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstB = 1'b0;
        pcIrdyIp = 0; npIrdyIp = 0; pcEomIp = 0; npEomIp = 0; pcParityIp = 0; npParityIp = 0;
        pcPayloadIp = '0; npPayloadIp = '0; pcTrdyEp = 0; npTrdyEp = 0;

        #12;
        checkOutput("rst_empty_mst",  {30'd0, emptyMst}, 32'd3);
        checkOutput("rst_trdy_ip",    {30'd0, npTrdyIp, pcTrdyIp}, 32'd3);
        checkOutput("rst_irdy_ep",    {30'd0, npIrdyEp, pcIrdyEp}, 32'd0);
        checkOutput("rst_msgip",      {30'd0, npMsgIp, pcMsgIp}, 32'd0);
        checkOutput("rst_pc_payload", pcPayloadEp, 32'd0);
        checkOutput("rst_np_payload", npPayloadEp, 32'd0);
        cycleStart();
        rstB = 1'b1;

        $display("[TB] single PC flit");
        cycleStart(); pcTrdyEp = 1; applyStimulus(0, 1, 1, 32'hA5A5_0001);
        midCycle();
        checkOutput("t1_trdy_ip",   {31'd0, pcTrdyIp}, 32'd1);
        checkOutput("t1_no_bypass", {31'd0, pcIrdyEp}, 32'd0);
        cycleStart(); idleIp(0);
        midCycle();
        checkOutput("t1_irdy_ep",   {31'd0, pcIrdyEp}, 32'd1);
        checkOutput("t1_head",      pcPayloadEp, 32'hA5A5_0001);
        checkOutput("t1_empty_busy", {30'd0, emptyMst}, 32'd2);
        cycleStart(); midCycle();
        checkOutput("t1_empty_after", {30'd0, emptyMst}, 32'd3);
        checkOutput("t1_irdy_after",  {31'd0, pcIrdyEp}, 32'd0);

        $display("[TB] PC fill and drain");
        cycleStart(); pcTrdyEp = 0; applyStimulus(0, 1, 0, 32'h1111_0000);
        midCycle(); checkOutput("t2_trdy_0", {31'd0, pcTrdyIp}, 32'd1);
        cycleStart(); applyStimulus(0, 1, 1, 32'h2222_0001);
        midCycle(); checkOutput("t2_trdy_1", {31'd0, pcTrdyIp}, 32'd1);
        cycleStart(); applyStimulus(0, 1, 0, 32'h3333_0002);
        midCycle(); checkOutput("t2_full_trdy", {31'd0, pcTrdyIp}, 32'd0);
        cycleStart(); pcTrdyEp = 1;
        midCycle();
        checkOutput("t2_held_trdy", {31'd0, pcTrdyIp}, 32'd0);
        checkOutput("t2_head_p0",   pcPayloadEp, 32'h1111_0000);
        cycleStart(); midCycle();
        checkOutput("t2_pushpop_trdy", {31'd0, pcTrdyIp}, 32'd1);
        cycleStart(); idleIp(0); midCycle();
        checkOutput("t2_head_p2",   pcPayloadEp, 32'h3333_0002);
        checkOutput("t2_occ_one",   {30'd0, emptyMst}, 32'd2);
        cycleStart(); midCycle();
        checkOutput("t2_drained", {30'd0, emptyMst}, 32'd3);

        $display("[TB] NP fenced behind earlier PC");
        cycleStart(); pcTrdyEp = 0; npTrdyEp = 1; applyStimulus(0, 1, 1, 32'h0000_00F1);
        midCycle();
        cycleStart(); idleIp(0); applyStimulus(1, 1, 0, 32'h0000_0E01);
        midCycle();
        cycleStart(); idleIp(1); midCycle();
        checkOutput("t3_fenced_a", {31'd0, npIrdyEp}, 32'd0);
        checkOutput("t3_both_busy", {30'd0, emptyMst}, 32'd0);
        cycleStart(); midCycle();
        checkOutput("t3_fenced_b", {31'd0, npIrdyEp}, 32'd0);
        cycleStart(); pcTrdyEp = 1; midCycle();
        checkOutput("t3_fenced_at_pop", {31'd0, npIrdyEp}, 32'd0);
        checkOutput("t3_pc_ready",      {31'd0, pcIrdyEp}, 32'd1);
        cycleStart(); midCycle();
        checkOutput("t3_released", {31'd0, npIrdyEp}, 32'd1);
        checkOutput("t3_np_head",  npPayloadEp, 32'h0000_0E01);
        cycleStart(); midCycle();
        checkOutput("t3_drained", {30'd0, emptyMst}, 32'd3);

        $display("[TB] PC passes stalled NP");
        cycleStart(); pcTrdyEp = 0; npTrdyEp = 0; applyStimulus(1, 1, 1, 32'h0000_0E02);
        midCycle();
        cycleStart(); idleIp(1); applyStimulus(0, 1, 0, 32'h0000_00F3);
        midCycle(); checkOutput("t4_np_unfenced", {31'd0, npIrdyEp}, 32'd1);
        cycleStart(); idleIp(0); pcTrdyEp = 1; midCycle();
        checkOutput("t4_pc_passes", {31'd0, pcIrdyEp}, 32'd1);
        cycleStart(); midCycle();
        checkOutput("t4_np_stalled", {31'd0, npIrdyEp}, 32'd1);
        checkOutput("t4_empty",      {30'd0, emptyMst}, 32'd1);
        cycleStart(); npTrdyEp = 1; midCycle();
        cycleStart(); midCycle();
        checkOutput("t4_drained", {30'd0, emptyMst}, 32'd3);

        $display("[TB] PC message in progress");
        cycleStart(); applyStimulus(0, 0, 1, 32'h4D00_0000);
        midCycle(); checkOutput("t5_msgip_0", {31'd0, pcMsgIp}, 32'd0);
        cycleStart(); applyStimulus(0, 0, 0, 32'h4D00_0001);
        midCycle(); checkOutput("t5_msgip_1", {31'd0, pcMsgIp}, 32'd1);
        cycleStart(); applyStimulus(0, 1, 1, 32'h4D00_0002);
        midCycle(); checkOutput("t5_msgip_2", {31'd0, pcMsgIp}, 32'd1);
        cycleStart(); idleIp(0);
        midCycle(); checkOutput("t5_msgip_done", {31'd0, pcMsgIp}, 32'd0);
        cycleStart(); midCycle();
        checkOutput("t5_drained", {30'd0, emptyMst}, 32'd3);

        $display("[TB] reset mid-message with both FIFOs full");
        cycleStart(); pcTrdyEp = 0; npTrdyEp = 0;
        applyStimulus(0, 0, 0, 32'h5200_0000); applyStimulus(1, 0, 1, 32'h5300_0000);
        midCycle();
        cycleStart(); applyStimulus(0, 0, 1, 32'h5200_0001); applyStimulus(1, 0, 0, 32'h5300_0001);
        midCycle();
        cycleStart(); idleIp(0); idleIp(1); midCycle();
        checkOutput("t6_full_empty", {30'd0, emptyMst}, 32'd0);
        checkOutput("t6_full_trdy",  {30'd0, npTrdyIp, pcTrdyIp}, 32'd0);
        checkOutput("t6_msgip_set",  {30'd0, npMsgIp, pcMsgIp}, 32'd3);
        checkOutput("t6_np_fenced",  {31'd0, npIrdyEp}, 32'd0);
        #1 rstB = 1'b0;
        pcExp.delete(); npExp.delete();
        cycleStart(); midCycle();
        checkOutput("t6_rst_empty", {30'd0, emptyMst}, 32'd3);
        checkOutput("t6_rst_trdy",  {30'd0, npTrdyIp, pcTrdyIp}, 32'd3);
        checkOutput("t6_rst_msgip", {30'd0, npMsgIp, pcMsgIp}, 32'd0);
        checkOutput("t6_rst_irdy",  {30'd0, npIrdyEp, pcIrdyEp}, 32'd0);
        checkOutput("t6_rst_pld",   pcPayloadEp | npPayloadEp, 32'd0);
        cycleStart(); rstB = 1'b1; midCycle();
        checkOutput("t6_post_empty", {30'd0, emptyMst}, 32'd3);

        $display("[TB] same-cycle PC and NP push");
        cycleStart(); pcTrdyEp = 1; npTrdyEp = 1;
        applyStimulus(0, 1, 0, 32'h6100_0000); applyStimulus(1, 1, 1, 32'h6200_0000);
        midCycle();
        cycleStart(); idleIp(0); idleIp(1); midCycle();
        checkOutput("t7_pc_ready",        {31'd0, pcIrdyEp}, 32'd1);
        checkOutput("t7_same_cycle_fence", {31'd0, npIrdyEp}, 32'd0);
        cycleStart(); midCycle();
        checkOutput("t7_np_released", {31'd0, npIrdyEp}, 32'd1);
        checkOutput("t7_pc_gone",     {31'd0, pcIrdyEp}, 32'd0);
        cycleStart(); midCycle();
        checkOutput("t7_drained", {30'd0, emptyMst}, 32'd3);

        checkOutput("pc_queue_drained", pcExp.size(), 32'd0);
        checkOutput("np_queue_drained", npExp.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
